muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit holding the MIPS HI/LO register pair. It sits beside the combinational ALU in the execute stage and handles the operations the ALU cannot finish in one cycle: MULT, MULTU, DIV, DIVU, MTHI and MTLO. It uses a start/busy/done handshake, so the pipeline control stalls MFHI/MFLO, or a new mul/div, while `busy` is high.

---
 rtl/muldiv_unit.sv | 204 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative 32-bit MIPS multiply/divide unit owning HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [63:0] acc_d;
  logic [31:0] opnd_q;
  logic [31:0] src_q;
  logic        is_div_q;
  logic        qneg_q;
  logic        rneg_q;
  logic        dz_q;
  logic        mt_pend_q;
  logic        mt_hi_q;
  logic        busy_q;
  logic        done_q;
  logic        dbz_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // Request decode: op[2]=0 is arithmetic, op[1] selects divide, op[0] unsigned
  logic        op_arith;
  logic        op_mt;
  logic        op_signed;
  logic        op_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  assign op_arith  = ~op[2];
  assign op_mt     = op[2] & ~op[1];
  assign op_signed = ~op[0];
  assign op_div    = op[1];
  assign a_neg     = op_signed & a[31];
  assign b_neg     = op_signed & b[31];
  assign mag_a     = a_neg ? (32'd0 - a) : a;
  assign mag_b     = b_neg ? (32'd0 - b) : b;

  // One iteration of the shared accumulator: shift-add or restoring divide
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;

  assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift[31:0] - opnd_q;

  always_comb begin
    acc_d = acc_q;
    if (is_div_q) begin
      if (div_ge) begin
        acc_d = {div_diff, acc_q[30:0], 1'b1};
      end else begin
        acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
      end
    end else begin
      acc_d = {mul_sum, acc_q[31:1]};
    end
  end

  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign prod_fix = qneg_q ? (64'd0 - acc_q) : acc_q;
  assign quot_fix = qneg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign rem_fix  = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      src_q     <= 32'd0;
      is_div_q  <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      mt_pend_q <= 1'b0;
      mt_hi_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      done_q <= 1'b0;

      // MTHI/MTLO commit one edge after acceptance without ever raising busy
      if (mt_pend_q) begin
        mt_pend_q <= 1'b0;
        done_q    <= 1'b1;
        if (mt_hi_q) begin
          hi_q <= src_q;
        end else begin
          lo_q <= src_q;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (op_arith) begin
              src_q    <= a;
              is_div_q <= op_div;
              qneg_q   <= a_neg ^ b_neg;
              rneg_q   <= a_neg;
              cnt_q    <= 5'd0;
              busy_q   <= 1'b1;
              if (op_div) begin
                opnd_q <= mag_b;
                acc_q  <= {32'd0, mag_a};
                if (b == 32'd0) begin
                  dz_q    <= 1'b1;
                  state_q <= S_FIX;
                end else begin
                  dz_q    <= 1'b0;
                  state_q <= S_CALC;
                end
              end else begin
                opnd_q  <= mag_a;
                acc_q   <= {32'd0, mag_b};
                dz_q    <= 1'b0;
                state_q <= S_CALC;
              end
            end else if (op_mt) begin
              src_q     <= a;
              mt_pend_q <= 1'b1;
              mt_hi_q   <= ~op[0];
            end
          end
        end

        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= S_FIX;
          end
        end

        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (dz_q) begin
            hi_q  <= src_q;
            lo_q  <= 32'hFFFF_FFFF;
            dbz_q <= 1'b1;
          end else if (is_div_q) begin
            hi_q  <= rem_fix;
            lo_q  <= quot_fix;
            dbz_q <= 1'b0;
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed self-checking bench for muldiv_unit.
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  muldiv_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request so that it is sampled by the next edge (E0); returns at E0+1.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges after E0 until done is seen (-1 on timeout) and busy-high cycles.
  task automatic wait_done(input int limit, output int edges, output int busy_cyc);
    bit seen;
    seen     = 1'b0;
    edges    = -1;
    busy_cyc = busy ? 1 : 0;
    for (int i = 1; i <= limit; i++) begin
      if (!seen) begin
        @(posedge clk); #1;
        if (done) begin
          edges = i;
          seen  = 1'b1;
        end else if (busy) begin
          busy_cyc++;
        end
      end
    end
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
  endtask

  task automatic test_multu_max();
    int e, bc;
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(60, e, bc);
    total++; if (e !== 33) begin bad++; $display("FAIL multu_latency got=%0d want=33", e); end
    total++; if (bc !== 33) begin bad++; $display("FAIL multu_busy_cycles got=%0d want=33", bc); end
    total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h want=fffffffe", hi); end
    total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h want=00000001", lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL multu_busy_at_done got=%b want=0", busy); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_width got=%b want=0", done); end
  endtask

  task automatic test_mult_signed();
    int e, bc;
    issue(3'b000, 32'hFFFF_FFFD, 32'd7);
    wait_done(60, e, bc);
    total++; if (e !== 33) begin bad++; $display("FAIL mult_latency got=%0d want=33", e); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", hi); end
    total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo got=%h want=ffffffeb", lo); end
    issue(3'b001, 32'hFFFF_FFFD, 32'd7);
    wait_done(60, e, bc);
    total++; if (hi !== 32'h0000_0006) begin bad++; $display("FAIL multu_neg_hi got=%h want=00000006", hi); end
    total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL multu_neg_lo got=%h want=ffffffeb", lo); end
  endtask

  task automatic test_div();
    int e, bc;
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_done(60, e, bc);
    total++; if (e !== 33) begin bad++; $display("FAIL div_latency got=%0d want=33", e); end
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_q got=%h want=fffffffd", lo); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_r got=%h want=ffffffff", hi); end
    issue(3'b011, 32'd100, 32'd7);
    wait_done(60, e, bc);
    total++; if (lo !== 32'd14) begin bad++; $display("FAIL divu_q got=%h want=0000000e", lo); end
    total++; if (hi !== 32'd2) begin bad++; $display("FAIL divu_r got=%h want=00000002", hi); end
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(60, e, bc);
    total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_q got=%h want=80000000", lo); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL div_ovf_r got=%h want=0", hi); end
  endtask

  task automatic test_div_zero();
    int e, bc;
    issue(3'b011, 32'h0000_1234, 32'd0);
    wait_done(10, e, bc);
    total++; if (e !== 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", e); end
    total++; if (bc !== 1) begin bad++; $display("FAIL dz_busy_cycles got=%0d want=1", bc); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", div_by_zero); end
    total++; if (hi !== 32'h0000_1234) begin bad++; $display("FAIL dz_hi got=%h want=00001234", hi); end
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_lo got=%h want=ffffffff", lo); end
    issue(3'b000, 32'd2, 32'd3);
    wait_done(60, e, bc);
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_sticky_mult got=%b want=1", div_by_zero); end
    total++; if (lo !== 32'd6) begin bad++; $display("FAIL dz_mult_lo got=%h want=00000006", lo); end
    issue(3'b011, 32'd9, 32'd3);
    wait_done(60, e, bc);
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dz_clear got=%b want=0", div_by_zero); end
    total++; if (lo !== 32'd3) begin bad++; $display("FAIL dz_next_q got=%h want=00000003", lo); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL dz_next_r got=%h want=0", hi); end
  endtask

  task automatic test_mt();
    int e, bc;
    issue(3'b100, 32'hAAAA_5555, 32'd0);
    wait_done(10, e, bc);
    total++; if (e !== 1) begin bad++; $display("FAIL mthi_latency got=%0d want=1", e); end
    total++; if (bc !== 0) begin bad++; $display("FAIL mthi_busy got=%0d want=0", bc); end
    total++; if (hi !== 32'hAAAA_5555) begin bad++; $display("FAIL mthi_hi got=%h want=aaaa5555", hi); end
    total++; if (lo !== 32'd3) begin bad++; $display("FAIL mthi_lo_kept got=%h want=00000003", lo); end
    issue(3'b101, 32'h0F0F_0F0F, 32'd0);
    wait_done(10, e, bc);
    total++; if (e !== 1) begin bad++; $display("FAIL mtlo_latency got=%0d want=1", e); end
    total++; if (bc !== 0) begin bad++; $display("FAIL mtlo_busy got=%0d want=0", bc); end
    total++; if (hi !== 32'hAAAA_5555) begin bad++; $display("FAIL mtlo_hi_kept got=%h want=aaaa5555", hi); end
    total++; if (lo !== 32'h0F0F_0F0F) begin bad++; $display("FAIL mtlo_lo got=%h want=0f0f0f0f", lo); end
  endtask

  task automatic test_reserved();
    int e, bc;
    issue(3'b110, 32'h1111_1111, 32'd5);
    wait_done(6, e, bc);
    total++; if (e !== -1) begin bad++; $display("FAIL rsv_done got=%0d want=-1", e); end
    total++; if (bc !== 0) begin bad++; $display("FAIL rsv_busy got=%0d want=0", bc); end
    total++; if (hi !== 32'hAAAA_5555) begin bad++; $display("FAIL rsv_hi got=%h want=aaaa5555", hi); end
    total++; if (lo !== 32'h0F0F_0F0F) begin bad++; $display("FAIL rsv_lo got=%h want=0f0f0f0f", lo); end
  endtask

  task automatic test_back_to_back();
    int e, bc;
    issue(3'b001, 32'd12, 32'd11);
    wait_done(60, e, bc);
    total++; if (lo !== 32'd132) begin bad++; $display("FAIL b2b_first_lo got=%h want=00000084", lo); end
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy); end
    wait_done(60, e, bc);
    total++; if (e !== 33) begin bad++; $display("FAIL b2b_latency got=%0d want=33", e); end
    total++; if (lo !== 32'd14) begin bad++; $display("FAIL b2b_q got=%h want=0000000e", lo); end
    total++; if (hi !== 32'd2) begin bad++; $display("FAIL b2b_r got=%h want=00000002", hi); end
  endtask

  task automatic test_ignore_busy();
    int  e;
    bit  seen;
    issue(3'b000, 32'd5, 32'd6);
    e    = -1;
    seen = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (!seen) begin
        @(posedge clk); #1;
        if (i == 9) begin
          start = 1'b1; op = 3'b011; a = 32'd99; b = 32'd3;
        end else if (i == 10) begin
          start = 1'b0;
        end
        if (done) begin
          e    = i;
          seen = 1'b1;
        end
      end
    end
    total++; if (e !== 33) begin bad++; $display("FAIL ign_latency got=%0d want=33", e); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL ign_hi got=%h want=0", hi); end
    total++; if (lo !== 32'd30) begin bad++; $display("FAIL ign_lo got=%h want=0000001e", lo); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_not_queued got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    int e, bc;
    issue(3'b000, 32'd5, 32'd6);
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL rmid_hi got=%h want=0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL rmid_lo got=%h want=0", lo); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b want=0", done); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    wait_done(40, e, bc);
    total++; if (e !== -1) begin bad++; $display("FAIL rmid_no_done got=%0d want=-1", e); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL rmid_lo_after got=%h want=0", lo); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'b000;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_multu_max();
    test_mult_signed();
    test_div();
    test_div_zero();
    test_mt();
    test_reserved();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
